// File: rtl/led_matrix_pwm_scan.sv
// led_matrix_pwm_scan
// Scans an 8x8 LED matrix one row at a time and applies 16-step PWM to
// the lit pixels of one of four built-in images. Brightness and image
// select are latched only at frame boundaries (or continuously while the
// scan is disabled), so a frame never mixes two brightness levels.
//
// Counter chain: psc (prescaler) -> slot (PWM step 0..15) -> row_idx (0..7).
// Outputs are registered decodes of the pre-edge counter state, so row and
// col lag the counters by one cycle.
module led_matrix_pwm_scan #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] level,
  input  logic [1:0] img_sel,
  input  logic       en,
  output logic [7:0] row,
  output logic [7:0] col,
  output logic       frame_start
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  // Counter state
  logic [PSC_W-1:0] psc;
  logic [3:0]       slot;
  logic [2:0]       row_idx;

  // Frame-stable copies of the brightness and image select
  logic [3:0]       level_q;
  logic [1:0]       img_q;

  // Chain strobes
  logic             slot_tick;
  logic             row_tick;
  logic             frame_wrap;

  // Next-state decode for the output registers
  logic [7:0]       row_d;
  logic [7:0]       col_d;
  logic             frame_start_d;
  logic [7:0]       rom_row;
  logic             pwm_on;

  // Built-in image ROM: one 8-bit column pattern per (image, row)
  function automatic logic [7:0] image_rom(input logic [1:0] img,
                                           input logic [2:0] r);
    logic [7:0] pat;
    case (img)
      2'd0:    pat = 8'hFF;
      2'd1:    pat = r[0] ? 8'h55 : 8'hAA;
      2'd2:    pat = ((r == 3'd0) || (r == 3'd7)) ? 8'hFF : 8'h81;
      default: pat = 8'h01 << r;
    endcase
    return pat;
  endfunction

  // Chain strobes: psc wrap is the slot tick, slot 15 + tick is the row tick
  always_comb begin
    slot_tick  = en && (psc == PSC_MAX);
    row_tick   = slot_tick && (slot == 4'd15);
    frame_wrap = row_tick && (row_idx == 3'd7);
  end

  // Prescaler, PWM slot and row counters; all held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      slot    <= 4'd0;
      row_idx <= 3'd0;
    end else if (!en) begin
      psc     <= '0;
      slot    <= 4'd0;
      row_idx <= 3'd0;
    end else begin
      if (psc == PSC_MAX) begin
        psc <= '0;
      end else begin
        psc <= psc + 1'b1;
      end
      if (slot_tick) begin
        slot <= slot + 4'd1;
      end
      if (row_tick) begin
        row_idx <= row_idx + 3'd1;
      end
    end
  end

  // Level/image latches: track inputs while disabled, reload only on frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 4'd0;
      img_q   <= 2'd0;
    end else if (!en || frame_wrap) begin
      level_q <= level;
      img_q   <= img_sel;
    end
  end

  // Decode of the current counter state into the next output values
  always_comb begin
    rom_row       = image_rom(img_q, row_idx);
    pwm_on        = (slot < level_q);
    row_d         = 8'h01 << row_idx;
    col_d         = rom_row & {8{pwm_on}};
    frame_start_d = (row_idx == 3'd0) && (slot == 4'd0) && (psc == '0);
  end

  // Registered row/column drive; blanked while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row         <= 8'h00;
      col         <= 8'h00;
      frame_start <= 1'b0;
    end else if (!en) begin
      row         <= 8'h00;
      col         <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      row         <= row_d;
      col         <= col_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// tb_led_matrix_pwm_scan
// Directed bench for the LED matrix scanner at PRESCALE=2
// (row period 32 cycles, frame period 256 cycles).
module tb_led_matrix_pwm_scan;

  localparam int PRESCALE = 2;
  localparam int ROW_CYC  = 16 * PRESCALE;
  localparam int FRM_CYC  = 128 * PRESCALE;

  logic       clk;
  logic       rst_n;
  logic [3:0] level;
  logic [1:0] img_sel;
  logic       en;
  logic [7:0] row;
  logic [7:0] col;
  logic       frame_start;

  int n_checks;
  int n_errors;

  led_matrix_pwm_scan #(.PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .level       (level),
    .img_sel     (img_sel),
    .en          (en),
    .row         (row),
    .col         (col),
    .frame_start (frame_start)
  );

  // Clock: posedges at 5, 15, ...; samples are taken on negedges
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hand-written image table (column bits for each image/row)
  function automatic logic [7:0] exp_rom(input int img, input int r);
    case (img)
      0: return 8'hFF;
      1: return (r % 2 == 0) ? 8'hAA : 8'h55;
      2: return (r == 0 || r == 7) ? 8'hFF : 8'h81;
      default: begin
        case (r)
          0: return 8'h01;
          1: return 8'h02;
          2: return 8'h04;
          3: return 8'h08;
          4: return 8'h10;
          5: return 8'h20;
          6: return 8'h40;
          default: return 8'h80;
        endcase
      end
    endcase
  endfunction

  // Expected {frame_start,row,col} at sample i (0 = first sample of a frame)
  function automatic logic [16:0] exp_out(input int i, input int lvl, input int img);
    int r;
    int t;
    logic [7:0] rv;
    logic [7:0] cv;
    r  = i / ROW_CYC;
    t  = i % ROW_CYC;
    rv = 8'h01 << r;
    cv = (t < lvl * PRESCALE) ? exp_rom(img, r) : 8'h00;
    return {(i == 0), rv, cv};
  endfunction

  // Check n consecutive negedge samples starting at frame position start
  task automatic check_span(input int start, input int n, input int lvl, input int img);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("scan_l%0d_i%0d_p%0d", lvl, img, start + k),
            {15'd0, frame_start, row, col},
            {15'd0, exp_out(start + k, lvl, img)});
    end
  endtask

  // Outputs all low (reset or disabled)
  task automatic check_idle(input string tag);
    check({tag, "_row"}, {24'd0, row}, 32'h00);
    check({tag, "_col"}, {24'd0, col}, 32'h00);
    check({tag, "_fs"},  {31'd0, frame_start}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    level    = 4'd0;
    img_sel  = 2'd0;

    // Reset state
    #3;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full brightness, solid image, two back-to-back frames
    level   = 4'd15;
    img_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    check_idle("disabled");
    en = 1'b1;
    check_span(0, FRM_CYC, 15, 0);
    check_span(0, FRM_CYC, 15, 0);

    // Dark level, checkerboard image: rows still scan, columns stay off
    en      = 1'b0;
    level   = 4'd0;
    img_sel = 2'd1;
    @(negedge clk);
    check_idle("en_off_a");
    en = 1'b1;
    check_span(0, FRM_CYC, 0, 1);

    // Level changed mid-frame takes effect on the following frame
    en      = 1'b0;
    level   = 4'd4;
    img_sel = 2'd2;
    @(negedge clk);
    en = 1'b1;
    check_span(0, 100, 4, 2);
    level = 4'd12;
    check_span(100, FRM_CYC - 100, 4, 2);
    check_span(0, FRM_CYC, 12, 2);

    // Diagonal image at half brightness
    en      = 1'b0;
    level   = 4'd8;
    img_sel = 2'd3;
    @(negedge clk);
    en = 1'b1;
    check_span(0, FRM_CYC, 8, 3);

    // Enable drop mid-row, then restart with a new level
    check_span(0, 40, 8, 3);
    en    = 1'b0;
    level = 4'd6;
    @(negedge clk);
    check_idle("en_drop");
    @(negedge clk);
    en = 1'b1;
    check_span(0, FRM_CYC, 6, 3);

    // Asynchronous reset mid-frame while row 08 is driven
    check_span(0, 100, 6, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    check_idle("rst_held");
    rst_n = 1'b1;
    // latches were cleared, so the first frame after reset is dark, image 0
    check_span(0, FRM_CYC, 0, 0);
    check_span(0, FRM_CYC, 6, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_pwm_scan.md
# led_matrix_pwm_scan

Downstream consumer of the 4-bit brightness level produced by the bouncing brightness counter. Scans an 8x8 LED matrix one row at a time and applies 16-step PWM to the lit pixels of the selected built-in image. The brightness level and image select are sampled only at frame boundaries, so a frame never tears. Outputs drive the matrix row and column drivers directly.

## Interface

- PRESCALE, 4: clock cycles per PWM slot; legal range 1..256.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- level  in  4  brightness from the counter stage; 0 = dark, 15 = maximum.
- img_sel  in  2  built-in image select.
- en  in  1  scan enable; level-sensitive.
- row  out  8  one-hot row drive, active-high; bit r = row r.
- col  out  8  column data for the active row, active-high; bit c = column c.
- frame_start  out  1  one-cycle pulse marking the first cycle of each frame.

## Operation

- Counters:
  - psc: 0..PRESCALE-1, width max(1, clog2(PRESCALE)).
  - slot: 0..15, 4 bits.
  - row_idx: 0..7, 3 bits.
- Counter chaining:
  - psc increments every cycle while en=1 and wraps to 0 after PRESCALE-1; the wrap is the slot tick.
  - slot advances on each slot tick; slot 15 plus a tick wraps slot to 0 and advances row_idx.
  - row_idx wraps from 7 to 0, which ends the frame.
- Latches: level_q and img_q.
  - Loaded from level and img_sel on every cycle while en=0.
  - Loaded on the cycle the frame wraps (row_idx=7, slot=15, psc=PRESCALE-1, en=1).
  - Held at all other times.
- Image ROM, row r:
  - img 0: 8'hFF.
  - img 1: 8'hAA for even r, 8'h55 for odd r.
  - img 2: 8'hFF for r=0 or r=7, otherwise 8'h81.
  - img 3: 8'h01 << r.
- PWM rule: a pixel is lit when the ROM bit is 1 and slot < level_q (4-bit unsigned compare).
  - level_q=0: never lit.
  - level_q=15: lit for 15 of 16 slots.
- en=0:
  - psc, slot and row_idx are forced to 0 synchronously.
  - Output registers load row=0, col=0, frame_start=0.
- en 0→1: the scan starts at row 0, slot 0, using the level and img_sel sampled on the last en=0 cycle.
- Reset (any time, including mid-frame):
  - All counters 0, level_q=0, img_q=0.
  - row=8'h00, col=8'h00, frame_start=0, immediately and asynchronously.
- Simultaneous events: a level/img_sel change on the frame-wrap cycle is captured for the next frame.

## Timing

- Outputs are registered. At each edge with en=1, the output registers load the decode of the pre-edge counter state:
  - row <= onehot(row_idx).
  - col <= ROM(img_q, row_idx) & {8{slot < level_q}}.
  - frame_start <= (row_idx=0 && slot=0 && psc=0).
- Latency: row and col lag the counters by one cycle. frame_start goes high on the first edge at which en is sampled high.
- Row period = 16*PRESCALE cycles; frame period = 128*PRESCALE cycles.
- frame_start repeats exactly every 128*PRESCALE cycles while en stays high.
- Effect of a level change:
  - Earliest: the frame after the next frame_start.
  - Latest: one full frame later.
- PRESCALE=1 is legal: the slot advances every cycle.

## Test plan

All scenarios use PRESCALE=2: row period 32 cycles, frame 256 cycles.

- Reset mid-frame: with row=8'h08, drive rst_n low between edges → row=8'h00, col=8'h00, frame_start=0 at once. Release rst_n with en=1 → frame_start pulses on the first edge and the scan restarts at row=8'h01.
- level=15, img_sel=0, en=1:
  - row steps 01,02,04,…,80, 32 cycles each.
  - Per row, col=8'hFF for 30 cycles, then 8'h00 for 2 cycles.
  - frame_start is high exactly once every 256 cycles.
- level=0, img_sel=1: col=8'h00 for an entire frame while row still scans all 8 rows.
- Mid-frame level change:
  - level=4 at frame start, changed to 12 while row=8'h08.
  - Rows 08..80 of that frame light col for 8 cycles per row.
  - The next frame lights for 24 cycles per row.
- img_sel=3, level=8: when row=8'h04, col=8'h04 for 16 cycles, then 8'h00 for 16 cycles. When row=8'h80, col=8'h80 for 16 cycles.
- Enable drop:
  - en 1→0 mid-row → row=8'h00, col=8'h00 after the next edge.
  - With level=6 during en=0, then en=1 → frame_start pulses, row=8'h01, and col is lit for 12 cycles per row.
